// File: rtl/win_pkg.sv
// Shared constants, types and saturation helpers for the Winograd signed MAC pipeline.
package win_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int ACC_W_DEF = 24;

    // Valid bits of the two operand stages ahead of the accumulator stage.
    typedef struct packed {
        logic v1;
        logic v2;
    } stage_valid_t;

    // Most-positive value of a w-bit two's-complement accumulator (ACC_MAX).
    function automatic logic [47:0] acc_max(input int w);
        return (48'd1 << (w - 1)) - 48'd1;
    endfunction

    // Most-negative value of a w-bit two's-complement accumulator (ACC_MIN).
    function automatic logic [47:0] acc_min(input int w);
        return ~acc_max(w);
    endfunction

endpackage

// File: rtl/win_umul_rows.sv
// Combinational WIDTH x WIDTH unsigned multiplier built from shifted partial-product rows.
module win_umul_rows #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    logic [2*WIDTH-1:0] prod_s;

    // Sum one shifted copy of a for every set bit of b.
    always_comb begin
        prod_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) begin
                prod_s = prod_s + ({{WIDTH{1'b0}}, a} << i);
            end else begin
                prod_s = prod_s;
            end
        end
    end

    assign p = prod_s;

endmodule

// File: rtl/win_mac_signed_pipe.sv
// Three-stage signed multiply-accumulate with per-group summation, overflow tracking
// and a full-pipeline stall driven by the single-entry result register.
module win_mac_signed_pipe
    import win_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    localparam logic [47:0]      MAX48   = acc_max(ACC_W);
    localparam logic [47:0]      MIN48   = acc_min(ACC_W);
    localparam logic [ACC_W-1:0] SAT_MAX = MAX48[ACC_W-1:0];
    localparam logic [ACC_W-1:0] SAT_MIN = MIN48[ACC_W-1:0];

    logic               en_s;
    stage_valid_t       vld_r;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s, mag_a_r, mag_b_r;
    logic               sign1_r, zero1_r, first1_r, last1_r;
    logic [2*WIDTH-1:0] prod_s, prod2_r;
    logic               sign2_r, zero2_r, first2_r, last2_r;
    logic [ACC_W:0]     ext_s, sp_s, sum_s;
    logic               ovf_s, sticky_next_s, sticky_r;
    logic [ACC_W-1:0]   acc_next_s, acc_r;

    // The only stall source is an unaccepted result, so in_ready never sees in_valid.
    assign en_s     = !(out_valid && !out_ready);
    assign in_ready = en_s;

    // Magnitudes are WIDTH-bit unsigned so the most-negative operand is kept exactly.
    assign mag_a_s = in_a[WIDTH-1] ? (~in_a + {{(WIDTH-1){1'b0}}, 1'b1}) : in_a;
    assign mag_b_s = in_b[WIDTH-1] ? (~in_b + {{(WIDTH-1){1'b0}}, 1'b1}) : in_b;

    win_umul_rows #(.WIDTH(WIDTH)) u_umul (
        .a (mag_a_r),
        .b (mag_b_r),
        .p (prod_s)
    );

    // Sign, re-extension and accumulation with overflow detection on ACC_W+1 bits.
    always_comb begin
        ext_s = {{(ACC_W + 1 - 2*WIDTH){1'b0}}, prod2_r};
        if (zero2_r) begin
            sp_s = '0;
        end else if (sign2_r) begin
            sp_s = ~ext_s + {{ACC_W{1'b0}}, 1'b1};
        end else begin
            sp_s = ext_s;
        end
        if (first2_r) begin
            sum_s = sp_s;
        end else begin
            sum_s = {acc_r[ACC_W-1], acc_r} + sp_s;
        end
        ovf_s = sum_s[ACC_W] ^ sum_s[ACC_W-1];
        if (SAT_EN && ovf_s) begin
            acc_next_s = sum_s[ACC_W] ? SAT_MIN : SAT_MAX;
        end else begin
            acc_next_s = sum_s[ACC_W-1:0];
        end
        sticky_next_s = (first2_r ? 1'b0 : sticky_r) | ovf_s;
    end

    // Operand stages S1 and S2; everything holds while the result is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r    <= '0;
            mag_a_r  <= '0;
            mag_b_r  <= '0;
            sign1_r  <= 1'b0;
            zero1_r  <= 1'b0;
            first1_r <= 1'b0;
            last1_r  <= 1'b0;
            prod2_r  <= '0;
            sign2_r  <= 1'b0;
            zero2_r  <= 1'b0;
            first2_r <= 1'b0;
            last2_r  <= 1'b0;
        end else if (en_s) begin
            vld_r.v1 <= in_valid;
            mag_a_r  <= mag_a_s;
            mag_b_r  <= mag_b_s;
            sign1_r  <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
            zero1_r  <= (in_a == '0) || (in_b == '0);
            first1_r <= in_first;
            last1_r  <= in_last;
            vld_r.v2 <= vld_r.v1;
            prod2_r  <= prod_s;
            sign2_r  <= sign1_r;
            zero2_r  <= zero1_r;
            first2_r <= first1_r;
            last2_r  <= last1_r;
        end
    end

    // Accumulator stage S3 and the single-entry result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= '0;
            sticky_r  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (en_s) begin
            if (vld_r.v2) begin
                acc_r    <= acc_next_s;
                sticky_r <= sticky_next_s;
            end
            out_valid <= vld_r.v2 && last2_r;
            if (vld_r.v2 && last2_r) begin
                out_data <= acc_next_s;
                out_ovf  <= sticky_next_s;
            end
        end
    end

endmodule

// File: tb/tb_win_mac_signed_pipe.sv
// Lock-step bench for five win_mac_signed_pipe configurations against an arithmetic group-sum model.
module tb_win_mac_signed_pipe;

    localparam int N = 5;
    localparam int W_T   [N] = '{8, 8, 8, 4, 16};
    localparam int AW_T  [N] = '{24, 16, 16, 8, 32};
    localparam int SAT_T [N] = '{1, 1, 0, 0, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_first, in_last, out_ready;
    logic [15:0] in_a16, in_b16;
    logic [N-1:0] ir, ov, oo;
    logic [23:0] od0;
    logic [15:0] od1, od2;
    logic [7:0]  od3;
    logic [31:0] od4;
    logic [47:0] od_x [N];

    typedef struct packed {
        logic [N-1:0][47:0] d;
        logic [N-1:0]       o;
        logic [31:0]        cyc;
    } exp_t;

    exp_t        q[$];
    logic [47:0] got0[$];
    longint      macc [N];
    bit          msticky [N];
    logic [47:0] last_d [N];
    logic        last_o [N];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          strict_lat = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        od_x[0] = {{24{od0[23]}}, od0};
        od_x[1] = {{32{od1[15]}}, od1};
        od_x[2] = {{32{od2[15]}}, od2};
        od_x[3] = {{40{od3[7]}}, od3};
        od_x[4] = {{16{od4[31]}}, od4};
    end

    win_mac_signed_pipe #(.WIDTH(8), .ACC_W(24), .SAT_EN(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .in_a(in_a16[7:0]), .in_b(in_b16[7:0]), .in_first(in_first), .in_last(in_last),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0), .out_ovf(oo[0]));
    win_mac_signed_pipe #(.WIDTH(8), .ACC_W(16), .SAT_EN(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .in_a(in_a16[7:0]), .in_b(in_b16[7:0]), .in_first(in_first), .in_last(in_last),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1), .out_ovf(oo[1]));
    win_mac_signed_pipe #(.WIDTH(8), .ACC_W(16), .SAT_EN(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
        .in_a(in_a16[7:0]), .in_b(in_b16[7:0]), .in_first(in_first), .in_last(in_last),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od2), .out_ovf(oo[2]));
    win_mac_signed_pipe #(.WIDTH(4), .ACC_W(8), .SAT_EN(1'b0)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
        .in_a(in_a16[3:0]), .in_b(in_b16[3:0]), .in_first(in_first), .in_last(in_last),
        .out_valid(ov[3]), .out_ready(out_ready), .out_data(od3), .out_ovf(oo[3]));
    win_mac_signed_pipe #(.WIDTH(16), .ACC_W(32), .SAT_EN(1'b1)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[4]),
        .in_a(in_a16), .in_b(in_b16), .in_first(in_first), .in_last(in_last),
        .out_valid(ov[4]), .out_ready(out_ready), .out_data(od4), .out_ovf(oo[4]));

    function automatic longint sx(input logic [15:0] v, input int w);
        longint r;
        r = longint'(v) & ((longint'(1) << w) - 1);
        if (r >= (longint'(1) << (w - 1))) r = r - (longint'(1) << w);
        return r;
    endfunction

    function automatic logic [15:0] v16(input int x);
        return x[15:0];
    endfunction

    function automatic logic [47:0] to48(input longint x);
        return x[47:0];
    endfunction

    // Group-sum reference: exact integer products, clamp or wrap into ACC_W bits.
    task automatic model_beat(input logic [15:0] a, input logic [15:0] b, input bit f, input bit l);
        exp_t   e;
        longint p, s, mx, mn;
        bit     o;
        e = '0;
        for (int i = 0; i < N; i++) begin
            p  = sx(a, W_T[i]) * sx(b, W_T[i]);
            s  = f ? p : macc[i] + p;
            mx = (longint'(1) << (AW_T[i] - 1)) - 1;
            mn = -mx - 1;
            o  = (s > mx) || (s < mn);
            if (o) begin
                if (SAT_T[i] != 0) begin
                    s = (s > mx) ? mx : mn;
                end else begin
                    s = s & ((longint'(1) << AW_T[i]) - 1);
                    if (s > mx) s = s - (longint'(1) << AW_T[i]);
                end
            end
            macc[i]    = s;
            msticky[i] = (f ? 1'b0 : msticky[i]) | o;
            e.d[i]     = to48(s);
            e.o[i]     = msticky[i];
        end
        e.cyc = cyc;
        if (l) q.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            macc[i]    = 0;
            msticky[i] = 1'b0;
        end
        q.delete();
    endtask

    // One clock: drive inputs, check handshakes and any transferring result, update the model.
    task automatic step(input bit v, input logic [15:0] a, input logic [15:0] b,
                        input bit f, input bit l, input bit ordy);
        exp_t e;
        bit   popped;
        in_valid = v; in_a16 = a; in_b16 = b; in_first = f; in_last = l; out_ready = ordy;
        #1;
        popped = 1'b0;
        e = (q.size() > 0) ? q[0] : '0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (ir[i] !== !(ov[i] && !ordy)) begin
                errors++;
                $display("FAIL in_ready dut%0d cyc=%0d got=%b want=%b", i, cyc, ir[i], !(ov[i] && !ordy));
            end
            if (ov[i] === 1'b1 && ordy) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_result dut%0d cyc=%0d got=%0h", i, cyc, od_x[i]);
                end else begin
                    if (od_x[i] !== e.d[i] || oo[i] !== e.o[i]) begin
                        errors++;
                        $display("FAIL result dut%0d cyc=%0d got=%0h/%b want=%0h/%b",
                                 i, cyc, od_x[i], oo[i], e.d[i], e.o[i]);
                    end
                    if (strict_lat) begin
                        checks++;
                        if (cyc != int'(e.cyc) + 3) begin
                            errors++;
                            $display("FAIL latency dut%0d got=%0d want=%0d", i, cyc - int'(e.cyc), 3);
                        end
                    end
                    popped    = 1'b1;
                    last_d[i] = od_x[i];
                    last_o[i] = oo[i];
                    if (i == 0) got0.push_back(od_x[0]);
                end
            end
        end
        if (popped) void'(q.pop_front());
        if (v && ir[0]) model_beat(a, b, f, l);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (ov[i] !== 1'b0 || oo[i] !== 1'b0 || od_x[i] !== 48'h0) begin
                errors++;
                $display("FAIL reset_state dut%0d got=%b/%b/%0h want=0/0/0", i, ov[i], oo[i], od_x[i]);
            end
        end
    endtask

    task automatic test_singles();
        logic [47:0] want [4];
        want = '{to48(16384), to48(-16256), to48(0), to48(-1)};
        got0.delete();
        strict_lat = 1'b1;
        step(1'b1, v16(-128), v16(-128), 1'b1, 1'b1, 1'b1);
        step(1'b1, v16(-128), v16(127),  1'b1, 1'b1, 1'b1);
        step(1'b1, v16(0),    v16(-5),   1'b1, 1'b1, 1'b1);
        step(1'b1, v16(-1),   v16(1),    1'b1, 1'b1, 1'b1);
        drain(4);
        strict_lat = 1'b0;
        checks++;
        if (got0.size() != 4) begin
            errors++;
            $display("FAIL singles_count got=%0d want=4", got0.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got0[k] !== want[k]) begin
                    errors++;
                    $display("FAIL singles_value k=%0d got=%0h want=%0h", k, got0[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_group();
        strict_lat = 1'b1;
        step(1'b1, v16(3),    v16(4),   1'b1, 1'b0, 1'b1);
        step(1'b1, v16(-2),   v16(5),   1'b0, 1'b0, 1'b1);
        step(1'b1, v16(127),  v16(127), 1'b0, 1'b0, 1'b1);
        step(1'b1, v16(-128), v16(1),   1'b0, 1'b1, 1'b1);
        drain(4);
        strict_lat = 1'b0;
        checks++;
        if (last_d[0] !== to48(16003) || last_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL group_sum got=%0h/%b want=%0h/0", last_d[0], last_o[0], to48(16003));
        end
    endtask

    task automatic test_back_to_back_backpressure();
        logic [47:0] hold_d;
        hold_d = '0;
        step(1'b1, v16(7),   v16(9),    1'b1, 1'b1, 1'b1);
        step(1'b1, v16(-3),  v16(11),   1'b1, 1'b1, 1'b1);
        step(1'b1, v16(100), v16(-100), 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                hold_d = od_x[0];
            end else begin
                checks++;
                if (od_x[0] !== hold_d || ov[0] !== 1'b1 || ir[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold k=%0d got=%0h/%b/%b want=%0h/1/0", k, od_x[0], ov[0], ir[0], hold_d);
                end
            end
            step(1'b1, v16($urandom_range(0, 255)), v16(-7), 1'b1, 1'b1, 1'b0);
        end
        drain(8);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL backpressure_lost got=%0d pending want=0", q.size());
        end
    endtask

    task automatic test_saturation();
        step(1'b1, v16(-128), v16(-128), 1'b1, 1'b0, 1'b1);
        step(1'b1, v16(-128), v16(-128), 1'b0, 1'b0, 1'b1);
        step(1'b1, v16(-128), v16(-128), 1'b0, 1'b1, 1'b1);
        drain(4);
        checks++;
        if (last_d[1] !== to48(32767) || last_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL sat_clamp got=%0h/%b want=%0h/1", last_d[1], last_o[1], to48(32767));
        end
        checks++;
        if (last_d[2] !== to48(-16384) || last_o[2] !== 1'b1) begin
            errors++;
            $display("FAIL sat_wrap got=%0h/%b want=%0h/1", last_d[2], last_o[2], to48(-16384));
        end
        step(1'b1, v16(-128), v16(-128), 1'b1, 1'b1, 1'b1);
        drain(4);
        checks++;
        if (last_d[1] !== to48(16384) || last_o[1] !== 1'b0) begin
            errors++;
            $display("FAIL sat_next_group got=%0h/%b want=%0h/0", last_d[1], last_o[1], to48(16384));
        end
    endtask

    task automatic test_reset_midgroup();
        step(1'b1, v16(9),  v16(9),  1'b1, 1'b1, 1'b1);
        step(1'b1, v16(50), v16(60), 1'b1, 1'b0, 1'b1);
        step(1'b1, v16(70), v16(-80), 1'b0, 1'b0, 1'b1);
        step(1'b1, v16(90), v16(90), 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (ov[i] !== 1'b0 || od_x[i] !== 48'h0 || oo[i] !== 1'b0 || ir[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_midgroup dut%0d got=%b/%0h/%b/%b want=0/0/0/1", i, ov[i], od_x[i], oo[i], ir[i]);
            end
        end
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        step(1'b1, v16(5),  v16(6), 1'b1, 1'b0, 1'b1);
        step(1'b1, v16(-7), v16(3), 1'b0, 1'b1, 1'b1);
        drain(4);
        checks++;
        if (last_d[0] !== to48(9) || last_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_sum got=%0h/%b want=%0h/0", last_d[0], last_o[0], to48(9));
        end
    endtask

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'hFF80;
            3:       return 16'h8000;
            4:       return 16'hFFF8;
            5:       return 16'h7F7F;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_random();
        int beats;
        beats = 0;
        for (int k = 0; k < 40000 && beats < 10000; k++) begin
            bit v;
            v = ($urandom_range(0, 3) != 0);
            if (v && (ir[0] === 1'b1 || !ov[0])) beats++;
            step(v, rnd_op(), rnd_op(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) != 0));
        end
        drain(6);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL random_drain got=%0d pending want=0", q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_a16 = 16'h0000; in_b16 = 16'h0000;
        for (int i = 0; i < N; i++) begin
            last_d[i] = '0;
            last_o[i] = 1'b0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_singles();
        test_group();
        test_back_to_back_backpressure();
        test_saturation();
        test_reset_midgroup();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
